// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit for the 8-bit ALU datapath.
// Every output is registered; decode happens on the DECODE->EXECUTE edge.
module alu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  output logic            instr_en,
  input  logic [15:0]     instr_data,
  output logic [2:0]      alu_cntr,
  input  logic [2:0]      alu_flags,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic [2:0]      rd_addr,
  output logic            rf_we,
  output logic            imm_sel,
  output logic [7:0]      imm,
  output logic [2:0]      flags_q,
  output logic            busy,
  output logic            halted,
  output logic            retire
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BGT  = 4'h9;
  localparam logic [3:0] OP_BCS  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Returns {alu_cntr[2:0], rf_we, imm_sel} for an opcode.
  function automatic logic [4:0] decode_op(input logic [3:0] op);
    case (op)
      4'h0:    decode_op = {3'b000, 1'b1, 1'b0};
      4'h1:    decode_op = {3'b001, 1'b1, 1'b0};
      4'h2:    decode_op = {3'b010, 1'b1, 1'b0};
      4'h3:    decode_op = {3'b011, 1'b1, 1'b0};
      4'h4:    decode_op = {3'b100, 1'b1, 1'b0};
      4'h5:    decode_op = {3'b101, 1'b1, 1'b0};
      4'h6:    decode_op = {3'b101, 1'b1, 1'b1};
      4'h7:    decode_op = {3'b100, 1'b0, 1'b0};
      default: decode_op = {3'b000, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic branch_taken(input logic [3:0] op, input logic [2:0] fl);
    case (op)
      OP_BEQ:  branch_taken = fl[0];
      OP_BGT:  branch_taken = fl[1];
      OP_BCS:  branch_taken = fl[2];
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  state_t          state_r, state_next_s;
  logic [PC_W-1:0] pc_r, pc_next_s;
  logic [15:0]     ir_r, ir_next_s;
  logic [2:0]      flags_r, flags_next_s;
  logic [4:0]      dec_s;
  logic [2:0]      cntr_next_s;
  logic            we_next_s;
  logic            isel_next_s;

  assign instr_addr = pc_r;
  assign flags_q    = flags_r;

  // Next-state, PC, IR and flag update logic.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    ir_next_s    = ir_r;
    flags_next_s = flags_r;
    case (state_r)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next_s = S_FETCH;
          pc_next_s    = RESET_PC;
        end else begin
          state_next_s = state_r;
        end
      end
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        ir_next_s    = instr_data;
        state_next_s = S_EXECUTE;
      end
      S_EXECUTE: begin
        // Opcodes 0-7 are the ALU-driving ones; their MSB is clear.
        if (ir_r[15] == 1'b0) begin
          flags_next_s = alu_flags;
        end else begin
          flags_next_s = flags_r;
        end
        if (ir_r[15:12] == OP_HALT) begin
          state_next_s = S_HALTED;
          pc_next_s    = pc_r;
        end else begin
          state_next_s = S_FETCH;
          if (branch_taken(ir_r[15:12], flags_r)) begin
            pc_next_s = ir_r[PC_W-1:0];
          end else begin
            pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Decoded control values for the cycle about to start.
  always_comb begin
    dec_s = decode_op(ir_next_s[15:12]);
    if (state_next_s == S_EXECUTE) begin
      cntr_next_s = dec_s[4:2];
      we_next_s   = dec_s[1];
      isel_next_s = dec_s[0];
    end else begin
      cntr_next_s = 3'b000;
      we_next_s   = 1'b0;
      isel_next_s = 1'b0;
    end
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= 16'h0000;
      flags_r  <= 3'b000;
      alu_cntr <= 3'b000;
      rf_we    <= 1'b0;
      imm_sel  <= 1'b0;
      ra_addr  <= 3'b000;
      rb_addr  <= 3'b000;
      rd_addr  <= 3'b000;
      imm      <= 8'h00;
      instr_en <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      retire   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      ir_r     <= ir_next_s;
      flags_r  <= flags_next_s;
      alu_cntr <= cntr_next_s;
      rf_we    <= we_next_s;
      imm_sel  <= isel_next_s;
      ra_addr  <= ir_next_s[8:6];
      rb_addr  <= ir_next_s[5:3];
      rd_addr  <= ir_next_s[11:9];
      imm      <= ir_next_s[7:0];
      instr_en <= (state_next_s == S_FETCH);
      busy     <= (state_next_s == S_FETCH) || (state_next_s == S_DECODE) ||
                  (state_next_s == S_EXECUTE);
      halted   <= (state_next_s == S_HALTED);
      retire   <= (state_next_s == S_EXECUTE);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an instruction-level program interpreter
// predicts each retired instruction; a negedge monitor compares DUT outputs.
module tb_alu_sequencer;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] cntr;
    logic       we;
    logic       isel;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
    logic [2:0] flags_before;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  instr_addr;
  logic        instr_en;
  logic [15:0] instr_data;
  logic [2:0]  alu_cntr;
  logic [2:0]  alu_flags;
  logic [2:0]  ra_addr, rb_addr, rd_addr;
  logic        rf_we, imm_sel;
  logic [7:0]  imm;
  logic [2:0]  flags_q;
  logic        busy, halted, retire;

  logic [15:0] rom [0:255];
  logic [2:0]  dir_f [0:15];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  m_pc;
  logic [2:0]  m_flags;
  exp_t        exp_q [$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_addr(instr_addr), .instr_en(instr_en), .instr_data(instr_data),
    .alu_cntr(alu_cntr), .alu_flags(alu_flags),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .rf_we(rf_we), .imm_sel(imm_sel), .imm(imm), .flags_q(flags_q),
    .busy(busy), .halted(halted), .retire(retire)
  );

  // Synchronous instruction ROM: one cycle read latency.
  always @(posedge clk) begin
    if (instr_en) instr_data <= rom[instr_addr];
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: compare every retired instruction against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (retire) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire actual=1 expected=0 addr=%0h", instr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr_addr", int'(instr_addr), int'(mon_e.pc));
          chk("alu_cntr",   int'(alu_cntr),   int'(mon_e.cntr));
          chk("rf_we",      int'(rf_we),      int'(mon_e.we));
          chk("imm_sel",    int'(imm_sel),    int'(mon_e.isel));
          chk("rd_addr",    int'(rd_addr),    int'(mon_e.rd));
          chk("ra_addr",    int'(ra_addr),    int'(mon_e.ra));
          chk("rb_addr",    int'(rb_addr),    int'(mon_e.rb));
          chk("imm",        int'(imm),        int'(mon_e.imm));
          chk("flags_q",    int'(flags_q),    int'(mon_e.flags_before));
          chk("exec_busy",  int'(busy),       1);
          chk("exec_halted", int'(halted),    0);
        end
      end else begin
        chk("idle_alu_cntr", int'(alu_cntr), 0);
        chk("idle_rf_we",    int'(rf_we),    0);
        chk("idle_imm_sel",  int'(imm_sel),  0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: execute one instruction at the ISA level, queue its expectation.
  task automatic issue(input logic [2:0] f, output logic [3:0] op);
    logic [15:0] ir;
    exp_t e;
    logic taken;
    ir = rom[m_pc];
    op = ir[15:12];
    e.pc = m_pc; e.rd = ir[11:9]; e.ra = ir[8:6]; e.rb = ir[5:3];
    e.imm = ir[7:0]; e.flags_before = m_flags;
    e.cntr = 3'b000; e.we = 1'b0; e.isel = 1'b0;
    case (op)
      4'h0: begin e.cntr = 3'b000; e.we = 1'b1; end
      4'h1: begin e.cntr = 3'b001; e.we = 1'b1; end
      4'h2: begin e.cntr = 3'b010; e.we = 1'b1; end
      4'h3: begin e.cntr = 3'b011; e.we = 1'b1; end
      4'h4: begin e.cntr = 3'b100; e.we = 1'b1; end
      4'h5: begin e.cntr = 3'b101; e.we = 1'b1; end
      4'h6: begin e.cntr = 3'b101; e.we = 1'b1; e.isel = 1'b1; end
      4'h7: e.cntr = 3'b100;
      default: e.cntr = 3'b000;
    endcase
    taken = (op == 4'h8 && m_flags[0]) || (op == 4'h9 && m_flags[1]) ||
            (op == 4'hA && m_flags[2]) || (op == 4'hB);
    exp_q.push_back(e);
    if (op < 4'h8) m_flags = f;
    if (op == 4'hF)  m_pc = m_pc;
    else if (taken)  m_pc = ir[7:0];
    else             m_pc = m_pc + 8'd1;
    alu_flags = f;
  endtask

  task automatic run(input int max_n, input bit directed, input bit poke, output bit hit_halt);
    logic [3:0] op;
    logic [2:0] f;
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_pc = 8'h00;
    hit_halt = 1'b0;
    for (int k = 0; k < max_n && !hit_halt; k++) begin
      f = directed ? dir_f[k] : 3'($urandom);
      issue(f, op);
      for (int c = 0; c < 3; c++) begin
        if (poke) start = ($urandom_range(0, 3) == 0);
        cyc();
        start = 1'b0;
      end
      if (op == 4'hF) hit_halt = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] op;
    bit         hh;
    rst_n = 1'b0; start = 1'b0; alu_flags = 3'b000;
    m_pc = 8'h00; m_flags = 3'b000;
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    for (int i = 0; i < 16; i++) dir_f[i] = 3'b000;
    cyc(); cyc();
    chk("rst_alu_cntr", int'(alu_cntr), 0);
    chk("rst_rf_we",    int'(rf_we),    0);
    chk("rst_instr_en", int'(instr_en), 0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_halted",   int'(halted),   0);
    chk("rst_retire",   int'(retire),   0);
    chk("rst_flags_q",  int'(flags_q),  0);
    chk("rst_pc",       int'(instr_addr), 0);
    rst_n = 1'b1;
    cyc();

    // Directed program: LDI, ADD, CMP/BEQ taken, CMP/BEQ not taken, JMP wrap.
    rom[8'h00] = 16'h6A05; rom[8'h01] = 16'h3050;
    rom[8'h02] = 16'h7000; rom[8'h03] = 16'h8020;
    rom[8'h20] = 16'h7000; rom[8'h21] = 16'h8030;
    rom[8'h22] = 16'hB0FF; rom[8'hFF] = 16'hC000;
    dir_f[1] = 3'b100; dir_f[2] = 3'b001; dir_f[3] = 3'b110;
    dir_f[4] = 3'b010; dir_f[6] = 3'b111; dir_f[7] = 3'b101;
    run(9, 1'b1, 1'b1, hh);
    chk("dir_pc_after_wrap", int'(instr_addr), 1);
    // Reset asynchronously in the middle of the ADD's EXECUTE cycle.
    issue(3'b100, op);
    cyc(); cyc();
    @(negedge clk);
    #1;
    chk("add_rf_we_before_rst", int'(rf_we), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rf_we",    int'(rf_we),    0);
    chk("async_alu_cntr", int'(alu_cntr), 0);
    chk("async_instr_en", int'(instr_en), 0);
    chk("async_busy",     int'(busy),     0);
    chk("async_retire",   int'(retire),   0);
    chk("async_flags_q",  int'(flags_q),  0);
    chk("async_pc",       int'(instr_addr), 0);
    m_flags = 3'b000;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random programs; HALT is made common so restarts from HALTED get exercised.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 16'($urandom);
        if ($urandom_range(0, 9) == 0) rom[i][15:12] = 4'hF;
      end
      run(120, 1'b0, 1'b1, hh);
      if (hh) begin
        for (int c = 0; c < 4; c++) begin
          chk("halt_halted",   int'(halted),   1);
          chk("halt_busy",     int'(busy),     0);
          chk("halt_instr_en", int'(instr_en), 0);
          chk("halt_retire",   int'(retire),   0);
          cyc();
        end
      end else begin
        rst_n = 1'b0;
        m_flags = 3'b000;
        cyc();
        rst_n = 1'b1;
        cyc();
      end
    end

    cyc(); cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
